// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, one-hot strobe bit positions and sequencer states.
package alu_pkg;

  localparam int SEL_W = 14;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int SEL_ADD   = 0;
  localparam int SEL_SUB   = 1;
  localparam int SEL_MUL   = 2;
  localparam int SEL_DIV   = 3;
  localparam int SEL_AND   = 4;
  localparam int SEL_OR    = 5;
  localparam int SEL_SHR   = 6;
  localparam int SEL_SHRA  = 7;
  localparam int SEL_SHL   = 8;
  localparam int SEL_ROR   = 9;
  localparam int SEL_ROL   = 10;
  localparam int SEL_NEG   = 11;
  localparam int SEL_NOT   = 12;
  localparam int SEL_INCPC = 13;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input sel_t s);
    return s[SEL_MUL] | s[SEL_DIV];
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op-code to one-hot ALU strobe decode; inc_pc overrides the op code.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0]       opcode,
  input  logic             inc_pc,
  output logic [SEL_W-1:0] sel,
  output logic             illegal
);

  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    if (inc_pc) begin
      sel[SEL_INCPC] = 1'b1;
    end else begin
      case (opcode)
        OP_ADD:  sel[SEL_ADD]  = 1'b1;
        OP_SUB:  sel[SEL_SUB]  = 1'b1;
        OP_SHR:  sel[SEL_SHR]  = 1'b1;
        OP_SHRA: sel[SEL_SHRA] = 1'b1;
        OP_SHL:  sel[SEL_SHL]  = 1'b1;
        OP_ROR:  sel[SEL_ROR]  = 1'b1;
        OP_ROL:  sel[SEL_ROL]  = 1'b1;
        OP_AND:  sel[SEL_AND]  = 1'b1;
        OP_OR:   sel[SEL_OR]   = 1'b1;
        OP_MUL:  sel[SEL_MUL]  = 1'b1;
        OP_DIV:  sel[SEL_DIV]  = 1'b1;
        OP_NEG:  sel[SEL_NEG]  = 1'b1;
        OP_NOT:  sel[SEL_NOT]  = 1'b1;
        default: illegal       = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control sequencer: holds one ALU strobe for K cycles, then captures the ALU result words.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic             inc_pc,
  input  logic [31:0]      Chigh,
  input  logic [31:0]      Clow,
  output logic [SEL_W-1:0] alu_sel,
  output logic [31:0]      Zhigh,
  output logic [31:0]      Zlow,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] MULDIV_LD = 4'(MULDIV_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  sel_t       dec_sel;
  logic       dec_illegal;

  alu_op_decode u_dec (
    .opcode  (opcode),
    .inc_pc  (inc_pc),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      alu_sel <= '0;
      Zhigh   <= '0;
      Zlow    <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dec_illegal) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              err     <= 1'b0;
              alu_sel <= dec_sel;
              cnt     <= is_muldiv(dec_sel) ? MULDIV_LD : SETTLE_LD;
              state   <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (cnt == 4'd0) begin
            // Only MUL/DIV produce a meaningful high word.
            Zlow    <= Clow;
            Zhigh   <= is_muldiv(alu_sel) ? Chigh : 32'd0;
            alu_sel <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          alu_sel <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic        inc_pc;
  logic [31:0] Chigh, Clow;
  logic [13:0] alu_sel;
  logic [31:0] Zhigh, Zlow;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;

  alu_sequencer dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .opcode  (opcode),
    .inc_pc  (inc_pc),
    .Chigh   (Chigh),
    .Clow    (Clow),
    .alu_sel (alu_sel),
    .Zhigh   (Zhigh),
    .Zlow    (Zlow),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // status word: {busy, done, err}
  function automatic logic [2:0] st();
    return {busy, done, err};
  endfunction

  initial begin
    clear = 1'b0; start = 1'b0; opcode = 5'd0; inc_pc = 1'b0;
    Chigh = '0; Clow = '0;
    #12;
    chk("rst_sel", alu_sel, 0);
    chk("rst_z", {Zhigh, Zlow}, 0);
    chk("rst_st", st(), 3'b000);
    step();
    clear = 1'b1;

    // ADD, first edge after clear release
    start = 1'b1; opcode = 5'b00011; Clow = 32'h0000000C; Chigh = 32'hFFFFFFFF;
    step();
    start = 1'b0;
    chk("add_sel", alu_sel, 14'h0001);
    chk("add_st_drive", st(), 3'b100);
    step();
    chk("add_sel_off", alu_sel, 0);
    chk("add_st_done", st(), 3'b110);
    chk("add_zlow", Zlow, 32'h0000000C);
    chk("add_zhigh", Zhigh, 32'h0);
    step();
    chk("add_st_idle", st(), 3'b000);

    // MUL, 4 strobe cycles; opcode changes mid-operation are ignored
    start = 1'b1; opcode = 5'b01111; Chigh = 32'h1; Clow = 32'h2;
    step();
    start = 1'b0; opcode = 5'b00011;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_sel%0d", i), alu_sel, 14'h0004);
      chk($sformatf("mul_done%0d", i), done, 1'b0);
      step();
    end
    chk("mul_sel_off", alu_sel, 0);
    chk("mul_st_done", st(), 3'b110);
    chk("mul_zhigh", Zhigh, 32'h1);
    chk("mul_zlow", Zlow, 32'h2);
    step();
    chk("mul_st_idle", st(), 3'b000);

    // illegal op code: straight to DONE, results retained
    start = 1'b1; opcode = 5'b11111; Chigh = 32'hAAAA5555; Clow = 32'h12345678;
    step();
    start = 1'b0;
    chk("ill_sel", alu_sel, 0);
    chk("ill_st_done", st(), 3'b111);
    chk("ill_z", {Zhigh, Zlow}, {32'h1, 32'h2});
    step();
    chk("ill_st_idle_err", st(), 3'b001);
    step();
    chk("ill_err_hold", err, 1'b1);

    // DIV aborted by clear in its 2nd strobe cycle
    start = 1'b1; opcode = 5'b10000; Chigh = 32'h77; Clow = 32'h88;
    step();
    start = 1'b0;
    chk("div_sel", alu_sel, 14'h0008);
    chk("div_err_clr", err, 1'b0);
    step();
    chk("div_sel2", alu_sel, 14'h0008);
    #2 clear = 1'b0;
    #1;
    chk("abort_sel", alu_sel, 0);
    chk("abort_z", {Zhigh, Zlow}, 0);
    chk("abort_st", st(), 3'b000);
    #2 clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("abort_nodone%0d", i), done, 1'b0);
    end

    // ADD after abort completes normally
    start = 1'b1; opcode = 5'b00011; Chigh = 32'h9; Clow = 32'h5;
    step();
    start = 1'b0;
    chk("add2_sel", alu_sel, 14'h0001);
    step();
    chk("add2_st_done", st(), 3'b110);
    chk("add2_z", {Zhigh, Zlow}, {32'h0, 32'h5});
    step();

    // SUB with start held through DRIVE and DONE, then IncPC in first IDLE cycle
    start = 1'b1; opcode = 5'b00100; Clow = 32'h3; Chigh = 32'h4;
    step();
    opcode = 5'b01111;
    chk("sub_sel", alu_sel, 14'h0002);
    step();
    chk("sub_sel_off", alu_sel, 0);
    chk("sub_st_done", st(), 3'b110);
    chk("sub_z", {Zhigh, Zlow}, {32'h0, 32'h3});
    step();
    chk("busy_ignored", st(), 3'b000);
    chk("busy_ignored_sel", alu_sel, 0);
    inc_pc = 1'b1; opcode = 5'b00100; Chigh = 32'hDEAD; Clow = 32'hBEEF;
    step();
    start = 1'b0; inc_pc = 1'b0;
    chk("incpc_sel", alu_sel, 14'h2000);
    step();
    chk("incpc_st_done", st(), 3'b110);
    chk("incpc_z", {Zhigh, Zlow}, {32'h0, 32'hBEEF});
    step();
    chk("final_idle", st(), 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
